// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> big-endian instruction words on the
// imem write port, with XOR checksum and a core hold until a good load.
module imem_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_N   = 17'(2 ** ADDR_W);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [CW-1:0]     len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic [CW-1:0]     wl_q, wl_d;

  logic        fire;
  logic        restart;
  logic [15:0] len_w;
  logic [31:0] word_w;
  logic [CW-1:0] wl_inc;

  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
  assign fire    = in_valid && in_ready;
  assign restart = start && ((state_q == S_IDLE) ||
                             (state_q == S_DONE) ||
                             (state_q == S_ERR));
  assign len_w   = {len_hi_q, in_data};
  assign word_w  = {word_q[23:0], in_data};
  assign wl_inc  = wl_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    acc_d    = acc_q;
    idle_d   = idle_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    error_d  = error_q;
    code_d   = code_q;
    wl_d     = wl_q;

    if (restart) begin
      state_d = S_LEN_HI;
      done_d  = 1'b0;
      error_d = 1'b0;
      code_d  = 2'd0;
      wl_d    = '0;
      acc_d   = '0;
      bcnt_d  = '0;
      idle_d  = '0;
    end else begin
      case (state_q)
        S_LEN_HI: if (fire) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: if (fire) begin
          if ({1'b0, len_w} > MAX_N) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = 2'd1;
          end else if (len_w == 16'd0) begin
            state_d = S_CHK;
          end else begin
            len_d   = len_w[CW-1:0];
            state_d = S_DATA;
          end
        end
        S_DATA: if (fire) begin
          word_d = word_w;
          acc_d  = acc_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = wl_q[ADDR_W-1:0];
            wdata_d = word_w;
            wl_d    = wl_inc;
            if (wl_inc == len_q) state_d = S_CHK;
          end
        end
        S_CHK: if (fire) begin
          if (in_data == acc_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = 2'd2;
          end
        end
        default: ;
      endcase

      // Starvation watchdog; it only runs while we are asking for bytes.
      if (in_ready) begin
        if (fire) begin
          idle_d = '0;
        end else if (idle_q == TO_LAST) begin
          state_d = S_ERR;
          error_d = 1'b1;
          code_d  = 2'd3;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
      acc_q    <= '0;
      idle_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= 2'd0;
      wl_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      acc_q    <= acc_d;
      idle_q   <= idle_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
      wl_q     <= wl_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  // A restart pulse in DONE re-freezes the core in that same cycle.
  assign cpu_hold     = (state_q != S_DONE) || start;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = code_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus restart,
// exact-timeout and mid-load reset sequences.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nb;
    logic [87:0] s;
    bit          gap;
    bit          e_done;
    bit          e_err;
    logic [1:0]  e_code;
    int          e_wl;
    int          e_nwr;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[6];

  int total = 0;
  int passed = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wq_addr.push_back(imem_waddr);
      wq_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bit acc;
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50; k++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("byte_accept", 32'(ok), 32'd1);
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_writes(input string nm, input int n,
                              input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] exp_d;
    chk({nm, "_nwr"}, 32'(wq_data.size()), 32'(n));
    for (int i = 0; i < n && i < wq_data.size(); i++) begin
      exp_d = (i == 0) ? d0 : d1;
      chk({nm, "_waddr"}, 32'(wq_addr[i]), 32'(i));
      chk({nm, "_wdata"}, wq_data[i], exp_d);
    end
  endtask

  task automatic run_row(input int r);
    vec_t v;
    bit fin;
    v = vecs[r];
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    for (int j = 0; j < v.nb; j++)
      send(v.s[8*(v.nb-1-j) +: 8], v.gap);
    fin = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done || error) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!fin) chk({v.name, "_finish"}, 32'(fin), 32'd1);
    @(posedge clk); #1;
    chk({v.name, "_done"}, 32'(done), 32'(v.e_done));
    chk({v.name, "_error"}, 32'(error), 32'(v.e_err));
    chk({v.name, "_code"}, 32'(err_code), 32'(v.e_code));
    chk({v.name, "_wl"}, 32'(words_loaded), 32'(v.e_wl));
    chk({v.name, "_hold"}, 32'(cpu_hold), 32'(!v.e_done));
    chk({v.name, "_ready"}, 32'(in_ready), 32'd0);
    check_writes(v.name, v.e_nwr, v.d0, v.d1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_we"}, 32'(imem_we), 32'd0);
    chk({nm, "_waddr"}, 32'(imem_waddr), 32'd0);
    chk({nm, "_wdata"}, imem_wdata, 32'd0);
    chk({nm, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_error"}, 32'(error), 32'd0);
    chk({nm, "_code"}, 32'(err_code), 32'd0);
    chk({nm, "_wl"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"normal", 11, 88'h0002200800058C090004AC, 1'b0,
                1'b1, 1'b0, 2'd0, 2, 2, 32'h20080005, 32'h8C090004};
    vecs[1] = '{"badchk", 11, 88'h0002200800058C090004AD, 1'b0,
                1'b0, 1'b1, 2'd2, 2, 2, 32'h20080005, 32'h8C090004};
    vecs[2] = '{"overflow", 2, 88'h0101, 1'b0,
                1'b0, 1'b1, 2'd1, 0, 0, 32'h0, 32'h0};
    vecs[3] = '{"timeout", 5, 88'h0001200800, 1'b0,
                1'b0, 1'b1, 2'd3, 0, 0, 32'h0, 32'h0};
    vecs[4] = '{"gapped", 11, 88'h0002200800058C090004AC, 1'b1,
                1'b1, 1'b0, 2'd0, 2, 2, 32'h20080005, 32'h8C090004};
    vecs[5] = '{"zerolen", 3, 88'h000000, 1'b0,
                1'b1, 1'b0, 2'd0, 0, 0, 32'h0, 32'h0};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_vals("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) run_row(r);

    // Back in DONE: restart must raise cpu_hold within the start cycle.
    run_row(0);
    chk("restart_hold_before", 32'(cpu_hold), 32'd0);
    start = 1'b1;
    #1;
    chk("restart_hold_same", 32'(cpu_hold), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);

    // Exact timeout edge, continuing from LEN_HI.
    wq_addr.delete();
    wq_data.delete();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk("to_15_error", 32'(error), 32'd0);
    @(posedge clk); #1;
    chk("to_16_error", 32'(error), 32'd1);
    chk("to_16_code", 32'(err_code), 32'd3);
    check_writes("to", 0, 32'h0, 32'h0);

    // Reset during the first write-strobe cycle.
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    chk("mid_we_pre", 32'(imem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("mid");
    @(posedge clk); #1;
    reset = 1'b0;
    check_writes("mid", 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    run_row(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the write side of the instruction memory that the pipeline's fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to the instruction-memory write port and verifies an XOR checksum.
- Drives cpu_hold, wired to the pipeline's stall input, so the core stays frozen until a load completes successfully.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.
- TIMEOUT_CYCLES, 1024, consecutive cycles with in_ready=1 and in_valid=0 before the load aborts.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  loader can accept a byte
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse
- imem_waddr  output  ADDR_W  word address of the write
- imem_wdata  output  32  instruction word to write
- cpu_hold  output  1  hold the core (drives pipeline stall)
- done  output  1  load completed, checksum good (sticky)
- error  output  1  load aborted (sticky)
- err_code  output  2  0 none, 1 length overflow, 2 checksum mismatch, 3 timeout
- words_loaded  output  ADDR_W+1  words written in the current load

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, err_code=0, words_loaded=0. State is IDLE.
- Frame format, in order:
  - LEN: 2 bytes, word count N, MSB first.
  - DATA: 4*N bytes, each word MSB first.
  - CHK: 1 byte, XOR of all DATA bytes.
- A byte is accepted on a rising clk edge when in_valid && in_ready. in_ready=1 only in LEN_HI, LEN_LO, DATA and CHK.
- States:
  - IDLE: start -> LEN_HI. Clear done, error, err_code, words_loaded, the checksum accumulator and the byte counter.
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte, forming N.
    - N > 2**ADDR_W -> ERR, code 1.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
  - DATA:
    - Each accepted byte shifts into the word register and XORs into the accumulator; the 2-bit byte counter increments.
    - On the 4th byte, the next cycle has imem_we=1, imem_waddr=word index, imem_wdata=assembled word, and words_loaded increments.
    - After word N-1 is accepted -> CHK.
    - in_ready stays 1 during the write cycle, so there is no bubble.
  - CHK: accept byte. Byte == accumulator -> DONE; otherwise -> ERR, code 2.
  - DONE: done=1, cpu_hold=0, in_ready=0.
  - ERR: error=1, cpu_hold=1, in_ready=0. Already-written words are not rolled back.
  - start in DONE or ERR restarts exactly as from IDLE, and cpu_hold returns to 1 in that same cycle.
  - start in any other state is ignored.
- Timeout:
  - The idle counter resets on every accepted byte and on entry to LEN_HI.
  - It increments each cycle with in_ready=1 && in_valid=0.
  - At TIMEOUT_CYCLES -> ERR, code 3.
  - A partially assembled word is discarded, with no write.
- cpu_hold=1 in every state except DONE.
- Word index wraps only by construction: the N limit guarantees imem_waddr never exceeds 2**ADDR_W-1.
- Reset asserted mid-load returns all outputs to their reset values immediately (asynchronously). No write strobe is emitted after reset asserts.

Test Plan:
- Normal 2-word load: start; bytes 00 02 20 08 00 05 8C 09 00 04 AC, valid every cycle.
  -> imem_we pulses twice: addr 0 data 0x20080005, then addr 1 data 0x8C090004.
  -> done=1, cpu_hold=0, words_loaded=2, err_code=0.
- Same stream but checksum byte AD:
  -> both words written; error=1, err_code=2, cpu_hold=1, done=0.
- Length bytes 01 01 (N=257, ADDR_W=8):
  -> ERR on the cycle after LEN_LO, err_code=1, no imem_we ever, in_ready=0.
- TIMEOUT_CYCLES=16: send 00 01 20 08 00, then hold in_valid=0:
  -> after 16 idle cycles error=1, err_code=3, no imem_we.
- Reset mid-load after 6 bytes:
  -> all outputs at reset values, cpu_hold=1.
  -> A following restart with the scenario-1 stream reproduces scenario 1 exactly.
- in_valid toggled every other cycle with the scenario-1 stream:
  -> identical writes and done.
- Zero-length frame 00 00 00:
  -> done=1, words_loaded=0, no imem_we.
